// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed seven-segment scan controller with per-digit register file
module seg7_scan_ctrl #(
    parameter int  N_DIGITS    = 8,
    parameter int  REFRESH_DIV = 100000,
    parameter int  BLINK_SCANS = 250,
    localparam int SW          = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                wr,
    input  logic [SW-1:0]       sel,
    input  logic [3:0]          num,
    input  logic                dp_in,
    input  logic                blank_in,
    input  logic                blink_in,
    input  logic                clr,
    output logic [7:0]          out_7Seg,
    output logic [N_DIGITS-1:0] out_Anodes
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_SCANS > 2) ? $clog2(BLINK_SCANS) : 1;

    logic [3:0]          r_val [N_DIGITS];
    logic [N_DIGITS-1:0] r_dp;
    logic [N_DIGITS-1:0] r_blank;
    logic [N_DIGITS-1:0] r_blink;

    logic [PW-1:0]       r_pcnt;
    logic [SW-1:0]       r_idx;
    logic [BW-1:0]       r_bcnt;
    logic                r_phase;

    logic [7:0]          r_seg;
    logic [N_DIGITS-1:0] r_an;

    logic                w_wr_en;
    logic                w_pwrap;
    logic                w_iwrap;
    logic                w_bwrap;
    logic [3:0]          w_cur_val;
    logic                w_dark;
    logic [6:0]          w_glyph;

    // Out-of-range selects are dropped here so the array index below stays legal.
    assign w_wr_en = wr & ({1'b0, sel} < (SW+1)'(N_DIGITS));

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_DIGITS; i++) r_val[i] <= 4'd0;
            r_dp    <= '0;
            r_blank <= '1;
            r_blink <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_DIGITS; i++) r_val[i] <= 4'd0;
            r_dp    <= '0;
            r_blank <= '1;
            r_blink <= '0;
        end else if (w_wr_en) begin
            r_val[sel]   <= num;
            r_dp[sel]    <= dp_in;
            r_blank[sel] <= blank_in;
            r_blink[sel] <= blink_in;
        end
    end

    assign w_pwrap = (r_pcnt == PW'(REFRESH_DIV - 1));
    assign w_iwrap = (r_idx == SW'(N_DIGITS - 1));
    assign w_bwrap = (r_bcnt == BW'(BLINK_SCANS - 1));

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_pcnt <= '0;
            r_idx  <= '0;
        end else if (w_pwrap) begin
            r_pcnt <= '0;
            r_idx  <= w_iwrap ? '0 : r_idx + 1'b1;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // Blink phase only moves when the scan returns to digit 0, so a slot never splits.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_pwrap && w_iwrap) begin
            if (w_bwrap) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    assign w_cur_val = r_val[r_idx];
    assign w_dark    = r_blank[r_idx] | (r_blink[r_idx] & r_phase);

    always_comb begin
        w_glyph = 7'b1111111;
        case (w_cur_val)
            4'h0: w_glyph = 7'b0000001;
            4'h1: w_glyph = 7'b1001111;
            4'h2: w_glyph = 7'b0010010;
            4'h3: w_glyph = 7'b0000110;
            4'h4: w_glyph = 7'b1001100;
            4'h5: w_glyph = 7'b0100100;
            4'h6: w_glyph = 7'b0100000;
            4'h7: w_glyph = 7'b0001111;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0000100;
            4'hA: w_glyph = 7'b0001000;
            4'hB: w_glyph = 7'b1100000;
            4'hC: w_glyph = 7'b0110001;
            4'hD: w_glyph = 7'b1000010;
            4'hE: w_glyph = 7'b0110000;
            4'hF: w_glyph = 7'b0111000;
            default: w_glyph = 7'b1111111;
        endcase
    end

    // Both buses are registered together so anodes and segments always change on the same edge.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_seg <= 8'hFF;
            r_an  <= '1;
        end else if (w_dark) begin
            r_seg <= 8'hFF;
            r_an  <= '1;
        end else begin
            r_seg <= {w_glyph, ~r_dp[r_idx]};
            r_an  <= ~(N_DIGITS'(1) << r_idx);
        end
    end

    assign out_7Seg   = r_seg;
    assign out_Anodes = r_an;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller that generalises the fixed 8-digit display block. It holds a per-digit register file (hex value, decimal point, blank, blink) written through a simple select/write port. It time-multiplexes the digits onto one shared segment bus with a programmable refresh prescaler and a scan-synchronous blink phase. It sits between user logic/switch inputs and the board's common-anode display pins.

## Interface
- N_DIGITS, 8, number of digits scanned; legal 2..16
- REFRESH_DIV, 100000, CLK cycles each digit is held (1 ms at 100 MHz); legal ≥ 2
- BLINK_SCANS, 250, complete scans per blink half-period; legal ≥ 1
- SW (localparam), max(1, $clog2(N_DIGITS)), select width

Ports:
- CLK  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-low reset
- wr  in  1  write strobe, sampled on CLK rising edge
- sel  in  SW  digit index to write; sel ≥ N_DIGITS is ignored
- num  in  4  hex value 0..F to store
- dp_in  in  1  decimal point for the written digit (1 = lit)
- blank_in  in  1  1 = digit dark
- blink_in  in  1  1 = digit blinks
- clr  in  1  synchronous clear of all digit registers
- out_7Seg  out  8  active-low segments, bit7..bit0 = A B C D E F G DP
- out_Anodes  out  N_DIGITS  active-low anode enables, bit i = digit i

## Operation
- Register file: N_DIGITS entries of {val[3:0], dp, blank, blink}.
- Reset/clr value of each entry: val=0, dp=0, blank=1, blink=0. The display is dark until a digit is written.
- Write: when wr=1 and sel<N_DIGITS, entry[sel] ← {num, dp_in, blank_in, blink_in}. When sel≥N_DIGITS, nothing changes.
- clr=1 and wr=1 in the same cycle: clr wins.
- Prescaler: pcnt counts 0..REFRESH_DIV-1. On wrap, digit index idx advances by 1 and wraps N_DIGITS-1 → 0.
- Blink: on the cycle where idx wraps to 0 and pcnt wraps, bcnt increments. When bcnt reaches BLINK_SCANS-1, bcnt → 0 and blink_phase toggles.
- Decode of the current entry:
  - Standard hex glyphs, active-low ABCDEFG.
  - Examples: 0=0000001, 1=1001111, 2=0010010, 5=0100100, 8=0000000, A=0001000, E=0110000, F=0111000.
  - DP bit is ~dp.
- Digit is dark if blank=1, or if blink=1 and blink_phase=1.
  - Dark digit: out_7Seg=8'hFF and all anodes deasserted (all ones).
  - Otherwise: out_Anodes = ~(1<<idx) and out_7Seg = {glyph, ~dp}.
- Outputs are always one-hot-low or all-high. Never two anodes low.

## Timing
- Reset (rst=0, asynchronous):
  - out_7Seg=8'hFF, out_Anodes=all ones.
  - idx=0, pcnt=0, bcnt=0, blink_phase=0.
  - All entries at their reset value.
- Outputs are registered from {idx, entry[idx], blink_phase}. The output reflects the state of the previous cycle.
- Write → output latency: a write on edge k to the currently scanned digit appears on out_7Seg after edge k+1.
- First cycle after rst deasserts: the output shows digit 0 state (dark at power-up).
- Each digit is driven for exactly REFRESH_DIV cycles. The full scan period is N_DIGITS·REFRESH_DIV cycles.
- Blink half-period is BLINK_SCANS·N_DIGITS·REFRESH_DIV cycles. blink_phase changes only at a scan boundary, so no digit changes blink state mid-slot.
- rst asserted mid-scan: all state returns to reset values immediately, with no glitch of two anodes low.
- clr does not reset idx, pcnt or blink state. Affected outputs go dark on the next edge.

## Test plan
Bench parameters: N_DIGITS=4, REFRESH_DIV=4, BLINK_SCANS=2.

- **Reset:** hold rst=0 for 3 cycles, then release.
  - out_7Seg=FF and out_Anodes=1111 throughout reset.
  - Display stays dark for a full scan of 16 cycles.
- **Write/scan:** write digits 0..3 = 2, 5, E, 1 with dp only on digit 1.
  - Anodes cycle 1110→1101→1011→0111, 4 cycles each.
  - Segments are 00100101, 01001000, 01100001, 10011111.
- **Out-of-range sel:** with N_DIGITS=5 instance, sel=6, wr=1, num=8.
  - No entry changes; the scan output is identical to the pre-write trace.
- **Blink:** digit 2 written with blink_in=1.
  - Digit 2 is lit for 2 scans (32 cycles), then dark for 32 cycles, repeating.
  - Other digits are unaffected.
- **Simultaneous clr+wr, then mid-scan reset:**
  - clr+wr on the same edge: all digits are dark on the next edge.
  - rst pulsed low while idx=2, pcnt=1: outputs FF/1111 immediately, and the scan restarts at idx=0.
